// File: rtl/div_iter_unit_if.sv
// Request/response bundle between M-extension issue and the iterative divider.
// The divider uses the slave side; issue/writeback logic uses the master side.
interface div_iter_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             iValid;
  logic             oReady;
  logic [1:0]       iDivOpEn;
  logic             iUnsigned;
  logic [XLEN-1:0]  iRs1;
  logic [XLEN-1:0]  iRs2;
  logic [TAG_W-1:0] iTag;
  logic             iFlush;
  logic             oValid;
  logic             iReady;
  logic [XLEN-1:0]  oResult;
  logic [TAG_W-1:0] oTag;
  logic             oBusy;

  modport slave (
    input  iValid, iDivOpEn, iUnsigned, iRs1, iRs2, iTag, iFlush, iReady,
    output oReady, oValid, oResult, oTag, oBusy
  );

  modport master (
    output iValid, iDivOpEn, iUnsigned, iRs1, iRs2, iTag, iFlush, iReady,
    input  oReady, oValid, oResult, oTag, oBusy
  );
endinterface

// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per
// cycle on magnitudes, sign fix-up afterwards, zero-divisor/overflow resolved at accept.
module div_iter_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  div_iter_unit_if.slave bus
);
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = '1;

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  quo_reg;
  logic [XLEN-1:0]  dvs_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             rem_sel_reg;
  logic [XLEN-1:0]  result_reg;
  logic [TAG_W-1:0] tag_reg;

  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  abs_a;
  logic [XLEN-1:0]  abs_b;
  logic             div_zero;
  logic             overflow;
  logic             rem_sel;
  logic [XLEN-1:0]  special_result;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    trial;
  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  quo_next;
  logic [XLEN-1:0]  q_fix;
  logic [XLEN-1:0]  r_fix;

  // Encoding 2'b11 resolves to remainder, 2'b00 to quotient.
  assign rem_sel = bus.iDivOpEn[0];

  always_comb begin
    a_neg    = !bus.iUnsigned && bus.iRs1[XLEN-1];
    b_neg    = !bus.iUnsigned && bus.iRs2[XLEN-1];
    abs_a    = a_neg ? -bus.iRs1 : bus.iRs1;
    abs_b    = b_neg ? -bus.iRs2 : bus.iRs2;
    div_zero = (bus.iRs2 == '0);
    overflow = !bus.iUnsigned && (bus.iRs1 == MIN_INT) && (bus.iRs2 == ALL_ONES);
    special_result = '0;
    if (div_zero)
      special_result = rem_sel ? bus.iRs1 : ALL_ONES;
    else if (overflow)
      special_result = rem_sel ? '0 : MIN_INT;
  end

  // Partial remainder needs XLEN+1 bits so a divisor near 2^XLEN still compares correctly.
  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    trial    = shifted - {1'b0, dvs_reg};
    rem_next = shifted[XLEN-1:0];
    quo_next = {quo_reg[XLEN-2:0], 1'b0};
    if (!trial[XLEN]) begin
      rem_next = trial[XLEN-1:0];
      quo_next = {quo_reg[XLEN-2:0], 1'b1};
    end
    q_fix = neg_q_reg ? -quo_reg : quo_reg;
    r_fix = neg_r_reg ? -rem_reg : rem_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      dvs_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rem_sel_reg <= 1'b0;
      result_reg  <= '0;
      tag_reg     <= '0;
    end else if (bus.iFlush) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.iValid) begin
            tag_reg     <= bus.iTag;
            rem_sel_reg <= rem_sel;
            if (div_zero || overflow) begin
              result_reg <= special_result;
              state_reg  <= DONE;
            end else begin
              quo_reg   <= abs_a;
              dvs_reg   <= abs_b;
              rem_reg   <= '0;
              neg_q_reg <= a_neg ^ b_neg;
              neg_r_reg <= a_neg;
              cnt_reg   <= CNT_W'(XLEN);
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1))
            state_reg <= FIX;
        end
        FIX: begin
          result_reg <= rem_sel_reg ? r_fix : q_fix;
          state_reg  <= DONE;
        end
        default: begin
          if (bus.iReady)
            state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.oReady  = (state_reg == IDLE);
  assign bus.oBusy   = (state_reg != IDLE);
  assign bus.oValid  = (state_reg == DONE);
  assign bus.oResult = result_reg;
  assign bus.oTag    = tag_reg;

  a_op_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                                bus.iValid |-> $onehot(bus.iDivOpEn));
endmodule

// File: tb/tb_div_iter_unit.sv
// Table-driven check of div_iter_unit with a result/tag/latency scoreboard,
// plus hand-built flush, back-pressure and async-reset sequences.
module tb_div_iter_unit;
  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  div_iter_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  div_iter_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]       op;
    logic             uns;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  exp;
    int               lat;
  } vec_t;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               lat;
  } exp_t;

  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_REM = 2'b01;

  vec_t vecs [16];
  exp_t sb [$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic uns, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
    bus.iValid    = 1'b1;
    bus.iDivOpEn  = op;
    bus.iUnsigned = uns;
    bus.iRs1      = a;
    bus.iRs2      = b;
    bus.iTag      = tag;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    exp_t e;
    int   lat;
    bit   seen;
    v = vecs[idx];
    @(negedge clk);
    check("ready_before", {63'd0, bus.oReady}, 64'd1);
    drive_req(v.op, v.uns, v.a, v.b, v.tag);
    sb.push_back('{res: v.exp, tag: v.tag, lat: v.lat});
    @(posedge clk);
    @(negedge clk);
    bus.iValid = 1'b0;
    check("ready_busy", {62'd0, bus.oReady, bus.oBusy}, 64'd1);
    lat  = 1;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      if (bus.oValid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      check("valid_timeout", 64'd0, 64'd1);
    end else begin
      check("result",  {32'd0, bus.oResult}, {32'd0, e.res});
      check("tag",     {59'd0, bus.oTag}, {59'd0, e.tag});
      check("latency", 64'(lat), 64'(e.lat));
    end
    $display("vec %0d: op=%b uns=%0d a=%h b=%h -> res=%h tag=%0d lat=%0d",
             idx, v.op, v.uns, v.a, v.b, bus.oResult, bus.oTag, lat);
    @(posedge clk);
    @(negedge clk);
    check("handshake_done", {62'd0, bus.oValid, bus.oReady}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int vseen;
    vecs[0]  = '{OP_DIV, 1'b1, 32'd100,      32'd7,        5'd3,  32'd14,       34};
    vecs[1]  = '{OP_REM, 1'b0, 32'hFFFFFFF9, 32'd2,        5'd4,  32'hFFFFFFFF, 34};
    vecs[2]  = '{OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 34};
    vecs[3]  = '{OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, 1};
    vecs[4]  = '{OP_REM, 1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h00000000, 1};
    vecs[5]  = '{OP_DIV, 1'b1, 32'd5,        32'd0,        5'd8,  32'hFFFFFFFF, 1};
    vecs[6]  = '{OP_REM, 1'b1, 32'd5,        32'd0,        5'd9,  32'd5,        1};
    vecs[7]  = '{OP_DIV, 1'b0, 32'hFFFFFFFB, 32'd0,        5'd10, 32'hFFFFFFFF, 1};
    vecs[8]  = '{OP_REM, 1'b0, 32'hFFFFFFFB, 32'd0,        5'd11, 32'hFFFFFFFB, 1};
    vecs[9]  = '{OP_DIV, 1'b0, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, 34};
    vecs[10] = '{OP_REM, 1'b0, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        34};
    vecs[11] = '{OP_DIV, 1'b1, 32'hFFFFFFFF, 32'd1,        5'd14, 32'hFFFFFFFF, 34};
    vecs[12] = '{OP_REM, 1'b1, 32'h80000000, 32'd3,        5'd15, 32'd2,        34};
    vecs[13] = '{OP_DIV, 1'b0, 32'h80000000, 32'd2,        5'd16, 32'hC0000000, 34};
    vecs[14] = '{OP_DIV, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd17, 32'd0,        34};
    vecs[15] = '{OP_REM, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd31, 32'h80000000, 34};

    rst_n = 1'b0;
    bus.iValid = 1'b0; bus.iDivOpEn = OP_DIV; bus.iUnsigned = 1'b0;
    bus.iRs1 = '0; bus.iRs2 = '0; bus.iTag = '0; bus.iFlush = 1'b0; bus.iReady = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", {25'd0, bus.oValid, bus.oBusy, bus.oReady, bus.oResult, bus.oTag},
          {25'd0, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0});
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(i);

    // Flush on the tenth CALC cycle: abandon, never signal valid.
    @(negedge clk);
    drive_req(OP_DIV, 1'b1, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    bus.iValid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", {63'd0, bus.oBusy}, 64'd1);
    bus.iFlush = 1'b1;
    @(negedge clk);
    bus.iFlush = 1'b0;
    check("flush_idle", {61'd0, bus.oValid, bus.oBusy, bus.oReady}, 64'd1);
    vseen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.oValid) vseen++;
    end
    check("flush_no_valid", 64'(vseen), 64'd0);
    $display("flush seq: valid pulses after flush=%0d", vseen);

    // Flush and request on the same edge: the request is dropped.
    drive_req(OP_DIV, 1'b1, 32'd9, 32'd3, 5'd2);
    bus.iFlush = 1'b1;
    @(negedge clk);
    bus.iValid = 1'b0;
    bus.iFlush = 1'b0;
    check("flush_beats_valid", {62'd0, bus.oBusy, bus.oReady}, 64'd1);
    $display("flush+valid seq: busy=%0d", bus.oBusy);

    // Back-pressure in DONE: outputs hold, no new accept.
    bus.iReady = 1'b0;
    drive_req(OP_DIV, 1'b1, 32'd5, 32'd0, 5'd9);
    @(negedge clk);
    drive_req(OP_REM, 1'b1, 32'd50, 32'd5, 5'd1);
    for (int c = 0; c < 5; c++) begin
      check("hold_outputs", {25'd0, bus.oValid, bus.oReady, bus.oResult, bus.oTag},
            {25'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 5'd9});
      @(negedge clk);
    end
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    @(negedge clk);
    check("hold_release", {62'd0, bus.oValid, bus.oReady}, 64'd1);
    $display("backpressure seq: res=%h tag=%0d", bus.oResult, bus.oTag);

    // Asynchronous reset mid-operation takes effect without a clock edge.
    drive_req(OP_DIV, 1'b1, 32'd100, 32'd7, 5'd3);
    @(negedge clk);
    bus.iValid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {25'd0, bus.oValid, bus.oBusy, bus.oReady, bus.oResult, bus.oTag},
          {25'd0, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0});
    $display("async reset seq: busy=%0d ready=%0d", bus.oBusy, bus.oReady);
    @(negedge clk);
    rst_n = 1'b1;

    // Unit is usable again after the reset.
    run_vec(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
